// File: rtl/accel_host_pkg.sv
// accel_host_pkg: definitions shared by the accelerator host sequencer.
//   state_e        - sequencer FSM states
//   CTRL_START_BIT - bit of ps_control that starts the accelerator
//   STAT_DONE_BIT  - bit of pl_status that reports accelerator completion
//   cnt_width()    - width of a counter that must reach n inclusive
package accel_host_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    KICK    = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam int CTRL_START_BIT = 0;
  localparam int STAT_DONE_BIT  = 0;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: drains N_OUT_WORDS words from a BRAM with a one-cycle
// read latency and presents them as a valid/ready stream.
//   clk, reset   - clock, synchronous active-high reset
//   go           - high while draining; low clears all drain state
//   addr         - BRAM byte address of the read being issued
//   rddata       - BRAM read data, valid one cycle after addr
//   m_data/m_valid/m_ready/m_last - output stream
//   finished     - one-cycle pulse when the last beat is accepted
module bram_stream_reader
  import accel_host_pkg::*;
#(
  parameter int BRAM_WIDTH  = 32,
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int N_OUT_WORDS = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [BRAM_WIDTH-1:0] rddata,
  output logic [BRAM_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  finished
);

  localparam int CW = cnt_width(N_OUT_WORDS);
  localparam logic [CW-1:0] LAST  = CW'(N_OUT_WORDS - 1);
  localparam logic [CW-1:0] TOTAL = CW'(N_OUT_WORDS);

  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [BRAM_WIDTH-1:0] buf_q [2];
  logic                  issue;
  logic                  pop;

  // A read may only be launched if its data is guaranteed a slot, counting
  // both stored words and the word still coming back from the BRAM.
  assign issue = go && (rd_cnt_q != TOTAL) &&
                 ((occ_q + {1'b0, inflight_q}) < 2'd2);
  assign pop      = m_valid && m_ready;
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = m_valid ? buf_q[rd_ptr_q] : '0;
  assign m_last   = m_valid && (out_cnt_q == LAST);
  assign finished = pop && (out_cnt_q == LAST);
  assign addr     = ADDR_WIDTH'(rd_cnt_q) * ADDR_WIDTH'(WORD_BYTES);

  always_comb begin
    rd_cnt_d   = rd_cnt_q + CW'(issue);
    inflight_d = issue;
    wr_ptr_d   = inflight_q ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    out_cnt_d  = out_cnt_q + CW'(pop);
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset || !go) begin
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: m_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (go && inflight_q) begin
      buf_q[wr_ptr_q] <= rddata;
    end
  end

endmodule

// File: rtl/accel_host_sequencer.sv
// accel_host_sequencer: PL-side host that runs one accelerator job:
// load input BRAM from a stream, start the accelerator, wait for done,
// then drain the output BRAM to a stream.
//   clk, reset          - clock, synchronous active-high reset
//   start/busy/done     - job control (start sampled only in IDLE)
//   error               - sticky watchdog flag (0 unless timeout enabled)
//   s_data/s_valid/s_ready          - input stream
//   m_data/m_valid/m_ready/m_last   - output stream
//   bram_addr_in/wrdata_in/we_in    - input BRAM write port (byte address)
//   bram_addr_out/bram_rddata_out   - output BRAM read port (1-cycle latency)
//   ps_control/pl_status            - accelerator start / done registers
//   bram_sel            - 1 hands both BRAMs to the accelerator
// Build option: define ACCEL_HOST_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise WAIT never times out and error is 0.
module accel_host_sequencer
  import accel_host_pkg::*;
#(
  parameter int BRAM_WIDTH     = 32,
  parameter int WORD_BYTES     = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int N_IN_WORDS     = 1024,
  parameter int N_OUT_WORDS    = 512,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [BRAM_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [BRAM_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH-1:0] bram_addr_in,
  output logic [BRAM_WIDTH-1:0] bram_wrdata_in,
  output logic [WORD_BYTES-1:0] bram_we_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [BRAM_WIDTH-1:0] bram_rddata_out,
  output logic [31:0]           ps_control,
  input  logic [31:0]           pl_status,
  output logic                  bram_sel
);

  localparam int IN_CW = cnt_width(N_IN_WORDS);
  localparam logic [IN_CW-1:0] IN_LAST = IN_CW'(N_IN_WORDS - 1);

  state_e           state_q, state_d;
  logic [IN_CW-1:0] in_cnt_q, in_cnt_d;
  logic             in_beat;
  logic             acc_done;
  logic             drain_finished;
  logic             timeout;
  logic             unused_cfg;

  assign acc_done   = pl_status[STAT_DONE_BIT];
  assign unused_cfg = ^{pl_status, 32'(TIMEOUT_CYCLES)};

`ifdef ACCEL_HOST_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  // wd_q holds the number of WAIT cycles already spent.
  assign timeout = (state_q == WAIT) && (wd_q == WD_LAST);
  assign wd_d    = (state_q == WAIT) ? wd_q + WD_W'(1) : '0;
  assign error   = error_q;

  always_comb begin
    error_d = error_q;
    if (state_q == IDLE && start) begin
      error_d = 1'b0;
    end else if (timeout && !acc_done) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign s_ready = (state_q == LOAD);
  assign in_beat = s_valid && s_ready;

  // Input BRAM writes are combinational so each beat lands in its own cycle.
  assign bram_we_in     = in_beat ? {WORD_BYTES{1'b1}} : '0;
  assign bram_wrdata_in = s_ready ? s_data : '0;
  assign bram_addr_in   = s_ready ? ADDR_WIDTH'(in_cnt_q) * ADDR_WIDTH'(WORD_BYTES) : '0;

  // KICK already hands the BRAMs over so the mux is settled before start.
  assign bram_sel = (state_q == KICK) || (state_q == WAIT) || (state_q == RELEASE);

  always_comb begin
    ps_control                 = '0;
    ps_control[CTRL_START_BIT] = (state_q == WAIT);
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          in_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_beat) begin
          in_cnt_d = in_cnt_q + IN_CW'(1);
          if (in_cnt_q == IN_LAST) state_d = KICK;
        end
      end
      KICK:    state_d = WAIT;
      WAIT: begin
        if (acc_done)     state_d = RELEASE;
        else if (timeout) state_d = DONE;
      end
      // Wait for the accelerator to drop done so the next job starts clean.
      RELEASE: if (!acc_done) state_d = DRAIN;
      DRAIN:   if (drain_finished) state_d = DONE;
      DONE: begin
        state_d  = IDLE;
        in_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
    end
  end

  bram_stream_reader #(
    .BRAM_WIDTH (BRAM_WIDTH),
    .WORD_BYTES (WORD_BYTES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_OUT_WORDS(N_OUT_WORDS)
  ) u_reader (
    .clk     (clk),
    .reset   (reset),
    .go      (state_q == DRAIN),
    .addr    (bram_addr_out),
    .rddata  (bram_rddata_out),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .finished(drain_finished)
  );

endmodule

// File: doc/accel_host_sequencer.md
Name: accel_host_sequencer

Overview:
PL-side host that replaces the PS for one accelerator job (e.g. activation). It streams input words into the input BRAM, raises start on ps_control[0], waits for pl_status[0], then reads the output BRAM and streams the results out with valid/ready. It owns the BRAM port mux select (bram_sel) that chooses between host and accelerator.

Parameters:
BRAM_WIDTH, 32, data word width
WORD_BYTES, 4, bytes per word; byte-addressed BRAM, address step = WORD_BYTES
ADDR_WIDTH, 12, BRAM byte-address width
N_IN_WORDS, 1024, words loaded per job; N_IN_WORDS*WORD_BYTES <= 2**ADDR_WIDTH
N_OUT_WORDS, 512, words drained per job; same bound
TIMEOUT_CYCLES, 65536, watchdog limit (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin job; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of job
error  out  1  sticky timeout flag; cleared by next accepted start
s_data  in  BRAM_WIDTH  input stream data
s_valid  in  1  input valid
s_ready  out  1  input ready
m_data  out  BRAM_WIDTH  output stream data
m_valid  out  1  output valid
m_ready  in  1  output ready
m_last  out  1  marks output beat N_OUT_WORDS-1
bram_addr_in  out  ADDR_WIDTH  input-BRAM byte address
bram_wrdata_in  out  BRAM_WIDTH  input-BRAM write data
bram_we_in  out  WORD_BYTES  input-BRAM byte enables
bram_addr_out  out  ADDR_WIDTH  output-BRAM byte address
bram_rddata_out  in  BRAM_WIDTH  output-BRAM read data, valid 1 cycle after address
ps_control  out  32  bit0 = accelerator start; bits 31:1 = 0
pl_status  in  32  bit0 = accelerator done
bram_sel  out  1  1 = accelerator owns both BRAMs

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Reset in any state aborts the job. ps_control and bram_sel read 0 on the cycle after reset is sampled.
- IDLE: start=1 -> LOAD; error cleared.
- LOAD:
  - s_ready=1.
  - Each beat with s_valid&&s_ready writes in the same cycle: we=all-ones, addr=cnt*WORD_BYTES, wrdata=s_data.
  - No beat in a cycle -> we=0.
  - After beat N_IN_WORDS-1: s_ready=0, go to KICK.
- KICK, 1 cycle: bram_sel=1, ps_control[0]=0 (mux settles before start rises).
- WAIT:
  - bram_sel=1, ps_control[0]=1.
  - pl_status[0]=1 -> RELEASE.
- RELEASE: ps_control[0]=0, bram_sel=1. Stay until pl_status[0]=0, then go to DRAIN with bram_sel=0.
- DRAIN:
  - Issue reads at addr=rd_cnt*WORD_BYTES.
  - Data is captured 1 cycle later into a 2-entry skid buffer.
  - A read issues only when occupancy + in-flight < 2, so nothing is dropped under backpressure.
  - m_valid=1 while the buffer is non-empty. m_data/m_last stay stable while m_valid&&!m_ready.
  - m_last=1 only on beat N_OUT_WORDS-1.
  - After that beat is accepted -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy=0 in IDLE.
- start while busy: ignored.
- Counters are sized clog2(N+1). Addresses never wrap within a job.

Optional Feature:
Macro ACCEL_HOST_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles.
  - On reaching TIMEOUT_CYCLES: ps_control[0]=0, bram_sel=0, error=1, skip DRAIN, go to DONE.
  - done pulses once. error holds until the next accepted start.
- Undefined: WAIT never times out; error is tied 0.

Decomposition:
- Package accel_host_pkg: state enum (IDLE, LOAD, KICK, WAIT, RELEASE, DRAIN, DONE) and constants CTRL_START_BIT=0, STAT_DONE_BIT=0.
- Sub-module bram_stream_reader: drain-side address counter, in-flight tracking, 2-entry skid buffer and m_* outputs. Ports: go, addr, rddata, m_*, finished.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs 0; after release busy=0, ps_control=0, bram_sel=0.
- Full job, ready always high: mock accelerator writes out[i]=in[i]+1; inputs 0..1023 -> outputs 1..512 in order; m_last only on beat 511; exactly one done pulse; ps_control[0] high only during WAIT.
- Output backpressure: m_ready alternates 1/0, plus 20-cycle stalls -> exactly 512 beats, no duplicates or losses; m_data unchanged on every stalled cycle.
- Input gaps: s_valid low every third cycle during LOAD -> bram_we_in=0 on gap cycles; addresses 0,4,8,...,4092 contiguous; KICK entered right after beat 1023.
- Misuse: start pulsed in WAIT -> ignored; reset during WAIT -> next cycle ps_control=0, bram_sel=0, busy=0; a new job then completes correctly.
- Timeout (ACCEL_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, accelerator never done) -> error=1 and ps_control[0]=0 after 100 WAIT cycles; done pulses once; m_valid never asserted.
